mem_stage: RTL and testbench

Memory-access stage of the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM register and consumes its outputs. It drives a multi-cycle data-memory handshake, resolves branch, jump and jr redirects, and holds the MEM/WB pipeline register that feeds write-back. When a memory access is still waiting for acknowledge, it stalls the upstream stages.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_stage_mem_wb.sv | 68 ++++++
 rtl/mem_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM stage of the 5-stage MIPS
// pipeline.
//   - state_e         : memory-handshake FSM states (IDLE = 0, BUSY = 1)
//   - WB_REGWRITE     : bit index of RegWrite in the write-back control field
//   - WB_MEMTOREG     : bit index of MemtoReg in the write-back control field
//   - TIMEOUT_DEFAULT : default number of cycles to wait for dm_ack
//   - CNT_W           : width of the timeout counter
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int unsigned WB_REGWRITE     = 0;
    localparam int unsigned WB_MEMTOREG     = 1;
    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned CNT_W           = 8;

endpackage

// File: rtl/mem_stage_mem_wb.sv
// mem_wb: MEM/WB pipeline register.
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   stall                       : MEM stage is waiting on memory; insert a bubble
//                                 and hold the data fields
//   bubble                      : squash this cycle's write-back (abort/reject)
//   rd_ack                      : an acknowledged read; capture rdata_in
//   wb_in/alu_in/mux_in/rdata_in: next-stage values from the MEM stage
//   wb_out/alu_out/mux_out/rdata_out: registered MEM/WB contents
module mem_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        bubble,
    input  logic        rd_ack,
    input  logic [1:0]  wb_in,
    input  logic [31:0] alu_in,
    input  logic [4:0]  mux_in,
    input  logic [31:0] rdata_in,
    output logic [1:0]  wb_out,
    output logic [31:0] alu_out,
    output logic [4:0]  mux_out,
    output logic [31:0] rdata_out
);

    logic [1:0]  wb_q,    wb_d;
    logic [31:0] alu_q,   alu_d;
    logic [4:0]  mux_q,   mux_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        wb_d    = wb_q;
        alu_d   = alu_q;
        mux_d   = mux_q;
        rdata_d = rdata_q;
        if (stall) begin
            // Bubble into write-back; everything else holds.
            wb_d = '0;
        end else begin
            wb_d  = bubble ? 2'b00 : wb_in;
            alu_d = alu_in;
            mux_d = mux_in;
            if (rd_ack) begin
                rdata_d = rdata_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q    <= '0;
            alu_q   <= '0;
            mux_q   <= '0;
            rdata_q <= '0;
        end else begin
            wb_q    <= wb_d;
            alu_q   <= alu_d;
            mux_q   <= mux_d;
            rdata_q <= rdata_d;
        end
    end

    assign wb_out    = wb_q;
    assign alu_out   = alu_q;
    assign mux_out   = mux_q;
    assign rdata_out = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage MIPS pipeline.
// Drives a multi-cycle data-memory handshake with timeout, resolves
// branch/jump/jr redirects and holds the MEM/WB register (mem_wb).
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   pi4_*                   : EX/MEM register outputs (target, zero, address,
//                             store data, dest reg, wb control, mem/branch ctrl)
//   Jump, jr, pi3_jump_addr : jump type and jump/jr target
//   dm_req/dm_we/dm_addr/dm_wdata/dm_rdata/dm_ack : data-memory handshake
//   mem_stall               : hold PC, IF/ID, ID/EX and EX/MEM
//   redirect/redirect_pc/flush : PC redirect and front-end squash
//   bus_err, align_err      : registered one-cycle error pulses
//   pi5_*                   : MEM/WB register outputs
// Parameter TIMEOUT (2..255): cycles to wait for dm_ack before aborting.
// Build option MEM_ALIGN_CHECK_EN: reject misaligned accesses with align_err;
// when undefined, dm_addr[1:0] is forced to zero and align_err is tied low.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pi4_add,
    input  logic        pi4_zero,
    input  logic [31:0] pi4_ADDR,
    input  logic [31:0] pi4_WD,
    input  logic [4:0]  pi4_MUX,
    input  logic [1:0]  pi4_wb,
    input  logic        pi4_MemRead,
    input  logic        pi4_MemWrite,
    input  logic        pi4_Branch,
    input  logic        Jump,
    input  logic        jr,
    input  logic [31:0] pi3_jump_addr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        mem_stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        bus_err,
    output logic        align_err,
    output logic [1:0]  pi5_wb,
    output logic [31:0] pi5_rdata,
    output logic [31:0] pi5_alu,
    output logic [4:0]  pi5_MUX
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             bus_err_q, bus_err_d;

    logic op;
    logic reject;
    logic abort;
    logic req;
    logic stall;
    logic rd_ack;
    logic jump_any;
    logic redirect_raw;

    assign op = pi4_MemRead | pi4_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;

    assign reject    = (state_q == IDLE) & op & (pi4_ADDR[1:0] != 2'b00);
    assign dm_addr   = pi4_ADDR;
    assign align_err_d = reject;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign align_err = align_err_q;
`else
    assign reject    = 1'b0;
    assign dm_addr   = {pi4_ADDR[31:2], 2'b00};
    assign align_err = 1'b0;
`endif

    always_comb begin
        req    = rst & (((state_q == IDLE) & op & ~reject) | (state_q == BUSY));
        abort  = (state_q == BUSY) & ~dm_ack & (cnt_q == TMO_LAST);
        stall  = req & ~dm_ack & ~abort;
        rd_ack = req & dm_ack & pi4_MemRead;
    end

    // The counter holds the number of stall cycles already elapsed for this
    // access, including the IDLE request cycle; so the BUSY entry value is 1
    // and abort at TIMEOUT-1 yields exactly TIMEOUT-1 stall cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = abort;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req & ~dm_ack) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(1);
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dm_ack | abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dm_req    = req;
    assign dm_we     = req & pi4_MemWrite;
    assign dm_wdata  = pi4_WD;
    assign mem_stall = stall;
    assign bus_err   = bus_err_q;

    // jr/Jump outrank a taken branch; no redirect while the pipe is frozen.
    assign jump_any     = Jump | jr;
    assign redirect_raw = jump_any | (pi4_Branch & pi4_zero);
    assign redirect     = rst & redirect_raw & ~stall;
    assign redirect_pc  = jump_any ? pi3_jump_addr : pi4_add;
    assign flush        = redirect;

    mem_wb u_mem_wb (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .bubble    (abort | reject),
        .rd_ack    (rd_ack),
        .wb_in     (pi4_wb),
        .alu_in    (pi4_ADDR),
        .mux_in    (pi4_MUX),
        .rdata_in  (dm_rdata),
        .wb_out    (pi5_wb),
        .alu_out   (pi5_alu),
        .mux_out   (pi5_MUX),
        .rdata_out (pi5_rdata)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with TIMEOUT=4.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later, registered outputs 1 ns after the rising edge.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] pi4_add;
    logic        pi4_zero;
    logic [31:0] pi4_ADDR;
    logic [31:0] pi4_WD;
    logic [4:0]  pi4_MUX;
    logic [1:0]  pi4_wb;
    logic        pi4_MemRead;
    logic        pi4_MemWrite;
    logic        pi4_Branch;
    logic        Jump;
    logic        jr;
    logic [31:0] pi3_jump_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        bus_err;
    logic        align_err;
    logic [1:0]  pi5_wb;
    logic [31:0] pi5_rdata;
    logic [31:0] pi5_alu;
    logic [4:0]  pi5_MUX;

    int unsigned errors = 0;
    int unsigned checks = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .pi4_add       (pi4_add),
        .pi4_zero      (pi4_zero),
        .pi4_ADDR      (pi4_ADDR),
        .pi4_WD        (pi4_WD),
        .pi4_MUX       (pi4_MUX),
        .pi4_wb        (pi4_wb),
        .pi4_MemRead   (pi4_MemRead),
        .pi4_MemWrite  (pi4_MemWrite),
        .pi4_Branch    (pi4_Branch),
        .Jump          (Jump),
        .jr            (jr),
        .pi3_jump_addr (pi3_jump_addr),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_rdata      (dm_rdata),
        .dm_ack        (dm_ack),
        .mem_stall     (mem_stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .bus_err       (bus_err),
        .align_err     (align_err),
        .pi5_wb        (pi5_wb),
        .pi5_rdata     (pi5_rdata),
        .pi5_alu       (pi5_alu),
        .pi5_MUX       (pi5_MUX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Non-memory ALU instruction writing r9.
    task automatic idle();
        pi4_add       = 32'h0;
        pi4_zero      = 1'b0;
        pi4_ADDR      = 32'h100;
        pi4_WD        = 32'h0;
        pi4_MUX       = 5'd9;
        pi4_wb        = 2'b01;
        pi4_MemRead   = 1'b0;
        pi4_MemWrite  = 1'b0;
        pi4_Branch    = 1'b0;
        Jump          = 1'b0;
        jr            = 1'b0;
        pi3_jump_addr = 32'h0;
        dm_rdata      = 32'h0;
        dm_ack        = 1'b0;
    endtask

    initial begin
        // Reset with a pending load and jump on the inputs.
        rst = 1'b0;
        idle();
        pi4_MemRead = 1'b1;
        Jump        = 1'b1;
        #2;
        chk("rst_dm_req",    dm_req,    0);
        chk("rst_stall",     mem_stall, 0);
        chk("rst_redirect",  redirect,  0);
        chk("rst_flush",     flush,     0);
        chk("rst_pi5_wb",    pi5_wb,    0);
        chk("rst_pi5_rdata", pi5_rdata, 0);
        chk("rst_pi5_alu",   pi5_alu,   0);
        chk("rst_pi5_MUX",   pi5_MUX,   0);
        chk("rst_bus_err",   bus_err,   0);
        chk("rst_align_err", align_err, 0);

        @(negedge clk);
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        chk("nop_pi5_wb",  pi5_wb,  2'b01);
        chk("nop_pi5_MUX", pi5_MUX, 9);

        // Zero-wait load.
        @(negedge clk);
        pi4_MemRead = 1'b1;
        pi4_ADDR    = 32'h10;
        pi4_wb      = 2'b11;
        pi4_MUX     = 5'd3;
        dm_ack      = 1'b1;
        dm_rdata    = 32'hDEADBEEF;
        #1;
        chk("ld0_dm_req",  dm_req,    1);
        chk("ld0_stall",   mem_stall, 0);
        chk("ld0_dm_we",   dm_we,     0);
        chk("ld0_dm_addr", dm_addr,   32'h10);
        @(posedge clk); #1;
        chk("ld0_pi5_rdata", pi5_rdata, 32'hDEADBEEF);
        chk("ld0_pi5_wb",    pi5_wb,    2'b11);
        chk("ld0_pi5_alu",   pi5_alu,   32'h10);
        chk("ld0_pi5_MUX",   pi5_MUX,   3);

        // Store acked on the 4th cycle: 3 stall cycles; ack coincides with
        // the TIMEOUT-1 count and must win.
        @(negedge clk);
        idle();
        pi4_MemWrite = 1'b1;
        pi4_ADDR     = 32'h20;
        pi4_WD       = 32'h12345678;
        pi4_MUX      = 5'd4;
        dm_rdata     = 32'h0BADF00D;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("st_stall",    mem_stall, 1);
            chk("st_dm_req",   dm_req,    1);
            chk("st_dm_we",    dm_we,     1);
            chk("st_dm_wdata", dm_wdata,  32'h12345678);
            chk("st_dm_addr",  dm_addr,   32'h20);
            @(posedge clk); #1;
            chk("st_pi5_wb_bubble", pi5_wb,    0);
            chk("st_pi5_rdata",     pi5_rdata, 32'hDEADBEEF);
            chk("st_bus_err",       bus_err,   0);
        end
        @(negedge clk);
        dm_ack = 1'b1;
        #1;
        chk("st_ack_stall",  mem_stall, 0);
        chk("st_ack_dm_req", dm_req,    1);
        chk("st_ack_dm_we",  dm_we,     1);
        @(posedge clk); #1;
        chk("st_done_bus_err", bus_err,   0);
        chk("st_done_pi5_wb",  pi5_wb,    2'b01);
        chk("st_done_pi5_alu", pi5_alu,   32'h20);
        chk("st_done_pi5_MUX", pi5_MUX,   4);
        chk("st_done_rdata",   pi5_rdata, 32'hDEADBEEF);
        @(negedge clk);
        idle();
        #1;
        chk("st_idle_dm_req", dm_req, 0);

        // Load never acked: abort after TIMEOUT-1 = 3 stall cycles.
        @(negedge clk);
        pi4_MemRead = 1'b1;
        pi4_ADDR    = 32'h30;
        pi4_wb      = 2'b11;
        pi4_MUX     = 5'd6;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("to_stall", mem_stall, 1);
            @(posedge clk); #1;
            chk("to_bus_err_low", bus_err, 0);
            chk("to_pi5_wb",      pi5_wb,  0);
        end
        @(negedge clk); #1;
        chk("to_abort_stall",  mem_stall, 0);
        chk("to_abort_dm_req", dm_req,    1);
        @(posedge clk); #1;
        chk("to_bus_err",   bus_err,   1);
        chk("to_pi5_wb_bb", pi5_wb,    0);
        chk("to_pi5_alu",   pi5_alu,   32'h30);
        chk("to_pi5_rdata", pi5_rdata, 32'hDEADBEEF);
        @(negedge clk);
        idle();
        #1;
        chk("to_idle_dm_req", dm_req, 0);
        @(posedge clk); #1;
        chk("to_bus_err_pulse", bus_err, 0);
        chk("to_after_pi5_wb",  pi5_wb,  2'b01);

        // Redirect priority.
        @(negedge clk);
        pi4_Branch    = 1'b1;
        pi4_zero      = 1'b1;
        pi4_add       = 32'h40;
        jr            = 1'b1;
        pi3_jump_addr = 32'h80;
        #1;
        chk("rd_jr_redirect", redirect,    1);
        chk("rd_jr_pc",       redirect_pc, 32'h80);
        chk("rd_jr_flush",    flush,       1);
        #1 jr = 1'b0;
        #1;
        chk("rd_br_redirect", redirect,    1);
        chk("rd_br_pc",       redirect_pc, 32'h40);
        #1 pi4_zero = 1'b0;
        #1;
        chk("rd_nt_redirect", redirect, 0);
        chk("rd_nt_flush",    flush,    0);

        // Stalled jump is suppressed; then reset while BUSY.
        @(negedge clk);
        idle();
        pi4_MemRead   = 1'b1;
        pi4_ADDR      = 32'h50;
        Jump          = 1'b1;
        pi3_jump_addr = 32'h80;
        #1;
        chk("sj_stall",    mem_stall, 1);
        chk("sj_redirect", redirect,  0);
        chk("sj_flush",    flush,     0);
        @(negedge clk); #1;
        chk("busy_dm_req", dm_req,    1);
        chk("busy_stall",  mem_stall, 1);
        #1 rst = 1'b0;
        #1;
        chk("mrst_dm_req",    dm_req,    0);
        chk("mrst_stall",     mem_stall, 0);
        chk("mrst_dm_we",     dm_we,     0);
        chk("mrst_redirect",  redirect,  0);
        chk("mrst_flush",     flush,     0);
        chk("mrst_pi5_wb",    pi5_wb,    0);
        chk("mrst_pi5_rdata", pi5_rdata, 0);
        chk("mrst_pi5_alu",   pi5_alu,   0);
        chk("mrst_pi5_MUX",   pi5_MUX,   0);
        chk("mrst_bus_err",   bus_err,   0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        #1;
        chk("mrst_idle_dm_req", dm_req, 0);
        @(posedge clk); #1;
        chk("mrst_after_pi5_wb", pi5_wb, 2'b01);

        // Misaligned load to 0x13.
        @(negedge clk);
        pi4_MemRead = 1'b1;
        pi4_ADDR    = 32'h13;
        pi4_wb      = 2'b11;
        pi4_MUX     = 5'd7;
`ifdef MEM_ALIGN_CHECK_EN
        #1;
        chk("al_dm_req", dm_req,    0);
        chk("al_stall",  mem_stall, 0);
        @(posedge clk); #1;
        chk("al_align_err", align_err, 1);
        chk("al_pi5_wb",    pi5_wb,    0);
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        chk("al_align_err_pulse", align_err, 0);
`else
        dm_ack   = 1'b1;
        dm_rdata = 32'hCAFEF00D;
        #1;
        chk("al_dm_req",  dm_req,    1);
        chk("al_dm_addr", dm_addr,   32'h10);
        chk("al_stall",   mem_stall, 0);
        @(posedge clk); #1;
        chk("al_align_err", align_err, 0);
        chk("al_pi5_wb",    pi5_wb,    2'b11);
        chk("al_pi5_rdata", pi5_rdata, 32'hCAFEF00D);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
